// File: rtl/tmds_decoder_if.sv
// Word/pixel bundle between a TMDS deserializer lane and its decoder.
// master drives raw words and consumes decoded pixels; slave is the decoder.
interface tmds_decoder_if;
    logic [9:0] tmds_in;
    logic       tmds_vld;
    logic       bitslip;
    logic       aligned;
    logic [7:0] dout;
    logic       de;
    logic       c0;
    logic       c1;
    logic       dvld;

    modport master (
        output tmds_in, tmds_vld,
        input  bitslip, aligned, dout, de, c0, c1, dvld
    );

    modport slave (
        input  tmds_in, tmds_vld,
        output bitslip, aligned, dout, de, c0, c1, dvld
    );
endinterface

// File: rtl/tmds_decoder.sv
// TMDS channel decoder: finds the word boundary from runs of control tokens,
// requests bitslips until locked, and decodes words through a 2-stage pipeline.
module tmds_decoder #(
    parameter int CTRL_RUN     = 16,
    parameter int SEARCH_LIMIT = 2048,
    parameter int SLIP_WAIT    = 8,
    parameter int LOSS_LIMIT   = 4096
) (
    input  logic          pclk,
    input  logic          rst_n,
    tmds_decoder_if.slave bus
);

    localparam int RUN_W    = $clog2(CTRL_RUN + 1);
    localparam int SEARCH_W = $clog2(SEARCH_LIMIT + 1);
    localparam int WAIT_W   = $clog2(SLIP_WAIT + 1);
    localparam int LOSS_W   = $clog2(LOSS_LIMIT + 1);

    localparam logic [RUN_W-1:0]    RUN_MAX    = RUN_W'(CTRL_RUN);
    localparam logic [SEARCH_W-1:0] SEARCH_MAX = SEARCH_W'(SEARCH_LIMIT);
    localparam logic [WAIT_W-1:0]   WAIT_LAST  = WAIT_W'(SLIP_WAIT - 1);
    localparam logic [LOSS_W-1:0]   LOSS_MAX   = LOSS_W'(LOSS_LIMIT);

    typedef enum logic [1:0] {SEARCH, SLIP, WAIT, LOCKED} state_e;

    // Returns {is_ctrl, c1, c0}.
    function automatic logic [2:0] ctrl_lookup(input logic [9:0] w);
        logic [2:0] res;
        case (w)
            10'h354: res = 3'b100;
            10'h0AB: res = 3'b101;
            10'h154: res = 3'b110;
            10'h2AB: res = 3'b111;
            default: res = 3'b000;
        endcase
        return res;
    endfunction

    function automatic logic [7:0] data_decode(input logic [9:0] w);
        logic [7:0] d;
        logic [7:0] res;
        d      = w[9] ? ~w[7:0] : w[7:0];
        res[0] = d[0];
        for (int i = 1; i < 8; i++) begin
            res[i] = w[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
        end
        return res;
    endfunction

    state_e              state_q, state_d;
    logic [RUN_W-1:0]    run_q, run_d, run_next;
    logic [SEARCH_W-1:0] search_q, search_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [LOSS_W-1:0]   loss_q, loss_d;
    logic                bitslip_q, bitslip_d;
    logic                aligned_q, aligned_d;
    logic [2:0]          in_ctrl;
    logic                run_hit;

    assign in_ctrl  = ctrl_lookup(bus.tmds_in);
    assign run_next = !bus.tmds_vld     ? run_q :
                      !in_ctrl[2]       ? '0 :
                      (run_q == RUN_MAX) ? run_q : run_q + RUN_W'(1);
    assign run_hit  = (run_next == RUN_MAX);

    // NOTE: every variable driven here gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        run_d     = run_next;
        search_d  = search_q;
        wait_d    = wait_q;
        loss_d    = loss_q;
        bitslip_d = 1'b0;
        aligned_d = aligned_q;
        case (state_q)
            SEARCH: begin
                if (bus.tmds_vld) search_d = search_q + SEARCH_W'(1);
                if (run_hit) begin
                    state_d   = LOCKED;
                    aligned_d = 1'b1;
                    search_d  = '0;
                    loss_d    = '0;
                end else if (search_d == SEARCH_MAX) begin
                    state_d   = SLIP;
                    bitslip_d = 1'b1;
                    search_d  = '0;
                    run_d     = '0;
                end
            end
            SLIP: begin
                state_d  = WAIT;
                run_d    = '0;
                search_d = '0;
                wait_d   = '0;
            end
            WAIT: begin
                run_d    = '0;
                search_d = '0;
                if (wait_q == WAIT_LAST) state_d = SEARCH;
                else                     wait_d  = wait_q + WAIT_W'(1);
            end
            LOCKED: begin
                if (run_hit)           loss_d = '0;
                else if (bus.tmds_vld) loss_d = loss_q + LOSS_W'(1);
                if (loss_d == LOSS_MAX) begin
                    state_d   = SEARCH;
                    aligned_d = 1'b0;
                    run_d     = '0;
                    search_d  = '0;
                    loss_d    = '0;
                end
            end
            default: state_d = SEARCH;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= SEARCH;
            run_q     <= '0;
            search_q  <= '0;
            wait_q    <= '0;
            loss_q    <= '0;
            bitslip_q <= 1'b0;
            aligned_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            run_q     <= run_d;
            search_q  <= search_d;
            wait_q    <= wait_d;
            loss_q    <= loss_d;
            bitslip_q <= bitslip_d;
            aligned_q <= aligned_d;
        end
    end

    // Decode pipeline: stage 1 captures the word, stage 2 decodes it.
    logic [9:0] s1_word_q;
    logic       s1_vld_q;
    logic [2:0] s1_ctrl;
    logic [7:0] s1_data;
    logic [7:0] dout_q;
    logic       de_q, c0_q, c1_q, dvld_q;

    assign s1_ctrl = ctrl_lookup(s1_word_q);
    assign s1_data = data_decode(s1_word_q);

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            s1_word_q <= '0;
            s1_vld_q  <= 1'b0;
            dout_q    <= '0;
            de_q      <= 1'b0;
            c0_q      <= 1'b0;
            c1_q      <= 1'b0;
            dvld_q    <= 1'b0;
        end else begin
            s1_word_q <= bus.tmds_in;
            s1_vld_q  <= bus.tmds_vld & aligned_q;
            dvld_q    <= s1_vld_q;
            if (s1_vld_q) begin
                if (s1_ctrl[2]) begin
                    de_q   <= 1'b0;
                    dout_q <= '0;
                    c1_q   <= s1_ctrl[1];
                    c0_q   <= s1_ctrl[0];
                end else begin
                    de_q   <= 1'b1;
                    dout_q <= s1_data;
                end
            end
        end
    end

    assign bus.bitslip = bitslip_q;
    assign bus.aligned = aligned_q;
    assign bus.dout    = dout_q;
    assign bus.de      = de_q;
    assign bus.c0      = c0_q;
    assign bus.c1      = c1_q;
    assign bus.dvld    = dvld_q;

endmodule

// File: tb/tb_tmds_decoder.sv
// Directed bench for tmds_decoder: lock, decode, slip, loss of lock and
// asynchronous reset, with expected values worked out by hand.
module tb_tmds_decoder;

    logic pclk;
    logic rst_n;

    tmds_decoder_if bus_if ();

    tmds_decoder dut (
        .pclk  (pclk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present a word for one cycle; returns just after the capturing edge.
    task automatic drive(input logic [9:0] w, input logic v);
        bus_if.tmds_in  = w;
        bus_if.tmds_vld = v;
        @(posedge pclk);
        #1;
    endtask

    task automatic idle();
        drive(10'h000, 1'b0);
    endtask

    task automatic apply_reset();
        bus_if.tmds_in  = 10'h000;
        bus_if.tmds_vld = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge pclk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_bitslip"}, 32'(bus_if.bitslip), 32'd0);
        check({tag, "_aligned"}, 32'(bus_if.aligned), 32'd0);
        check({tag, "_dout"},    32'(bus_if.dout),    32'd0);
        check({tag, "_de"},      32'(bus_if.de),      32'd0);
        check({tag, "_c"},       32'({bus_if.c1, bus_if.c0}), 32'd0);
        check({tag, "_dvld"},    32'(bus_if.dvld),    32'd0);
    endtask

    task automatic check_pix(input string tag, input logic [7:0] dout, input logic de,
                             input logic [1:0] c, input logic dvld);
        check({tag, "_dout"}, 32'(bus_if.dout), 32'(dout));
        check({tag, "_de"},   32'(bus_if.de),   32'(de));
        check({tag, "_c"},    32'({bus_if.c1, bus_if.c0}), 32'(c));
        check({tag, "_dvld"}, 32'(bus_if.dvld), 32'(dvld));
    endtask

    // Sixteen 0x354 tokens: still unaligned after 15, aligned after 16.
    task automatic lock_seq(input string tag);
        for (int i = 0; i < 15; i++) drive(10'h354, 1'b1);
        check({tag, "_pre15"}, 32'(bus_if.aligned), 32'd0);
        drive(10'h354, 1'b1);
        check({tag, "_lock16"}, 32'(bus_if.aligned), 32'd1);
    endtask

    // Feed 0x1FF until the search limit expires; bitslip must fire on word 2048.
    task automatic search_to_slip(input string tag);
        for (int i = 0; i < 2047; i++) drive(10'h1FF, 1'b1);
        check({tag, "_noslip2047"}, 32'(bus_if.bitslip), 32'd0);
        drive(10'h1FF, 1'b1);
        check({tag, "_slip2048"}, 32'(bus_if.bitslip), 32'd1);
    endtask

    typedef struct {
        logic [9:0] word;
        logic [7:0] dout;
        logic       de;
        logic [1:0] c;
    } vec_t;

    vec_t vecs [10];

    initial begin
        vecs[0] = '{10'h0AB, 8'h00, 1'b0, 2'b01};
        vecs[1] = '{10'h100, 8'h00, 1'b1, 2'b01};
        vecs[2] = '{10'h3FF, 8'h00, 1'b1, 2'b01};
        vecs[3] = '{10'h000, 8'hFE, 1'b1, 2'b01};
        vecs[4] = '{10'h1FF, 8'h01, 1'b1, 2'b01};
        vecs[5] = '{10'h155, 8'hFF, 1'b1, 2'b01};
        vecs[6] = '{10'h2F0, 8'hEF, 1'b1, 2'b01};
        vecs[7] = '{10'h154, 8'h00, 1'b0, 2'b10};
        vecs[8] = '{10'h2AB, 8'h00, 1'b0, 2'b11};
        vecs[9] = '{10'h354, 8'h00, 1'b0, 2'b00};
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dvld_seen;
        rst_n           = 1'b0;
        bus_if.tmds_in  = 10'h000;
        bus_if.tmds_vld = 1'b0;
        repeat (3) @(posedge pclk);
        #1;
        check_zero("reset");
        rst_n = 1'b1;

        // Lock from 16 tokens; no pixel output while unaligned.
        dvld_seen = 0;
        for (int i = 0; i < 15; i++) begin
            drive(10'h354, 1'b1);
            if (bus_if.dvld) dvld_seen++;
        end
        check("lock_pre15", 32'(bus_if.aligned), 32'd0);
        drive(10'h354, 1'b1);
        if (bus_if.dvld) dvld_seen++;
        check("lock_16", 32'(bus_if.aligned), 32'd1);
        idle();
        if (bus_if.dvld) dvld_seen++;
        check("dvld_before_lock", 32'(dvld_seen), 32'd0);

        // Isolated words: result two cycles later, then held with dvld low.
        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].word, 1'b1);
            idle();
            check_pix($sformatf("vec%0d", i), vecs[i].dout, vecs[i].de, vecs[i].c, 1'b1);
            idle();
            check_pix($sformatf("hold%0d", i), vecs[i].dout, vecs[i].de, vecs[i].c, 1'b0);
        end

        // Back-to-back words stream at one per cycle.
        drive(10'h000, 1'b1);
        drive(10'h1FF, 1'b1);
        check_pix("stream0", 8'hFE, 1'b1, 2'b00, 1'b1);
        idle();
        check_pix("stream1", 8'h01, 1'b1, 2'b00, 1'b1);

        // Loss of lock: re-qualify, then exactly LOSS_LIMIT data words.
        drive(10'h100, 1'b1);
        for (int i = 0; i < 16; i++) drive(10'h354, 1'b1);
        check("loss_requal", 32'(bus_if.aligned), 32'd1);
        for (int i = 0; i < 4095; i++) drive(10'h100, 1'b1);
        check("loss_4095", 32'(bus_if.aligned), 32'd1);
        drive(10'h100, 1'b1);
        check("loss_4096", 32'(bus_if.aligned), 32'd0);
        check("loss_bitslip", 32'(bus_if.bitslip), 32'd0);
        lock_seq("relock_after_loss");

        // A data word inside the run restarts the count.
        apply_reset();
        for (int i = 0; i < 15; i++) drive(10'h354, 1'b1);
        drive(10'h100, 1'b1);
        for (int i = 0; i < 15; i++) drive(10'h354, 1'b1);
        check("broken_run", 32'(bus_if.aligned), 32'd0);
        drive(10'h354, 1'b1);
        check("broken_run_16", 32'(bus_if.aligned), 32'd1);

        // Search limit -> single bitslip pulse, input ignored while waiting.
        apply_reset();
        search_to_slip("slip");
        for (int i = 0; i < 9; i++) begin
            drive(10'h354, 1'b1);
            check($sformatf("slip_gap%0d", i), 32'(bus_if.bitslip), 32'd0);
        end
        check("slip_wait_unaligned", 32'(bus_if.aligned), 32'd0);
        lock_seq("slip_resume");

        // Reset asserted during the bitslip pulse.
        apply_reset();
        search_to_slip("rst_slip");
        rst_n = 1'b0;
        #1;
        check_zero("rst_in_slip");
        @(posedge pclk);
        #1;
        rst_n = 1'b1;
        lock_seq("relock_after_slip_rst");

        // Reset asserted during a locked data burst.
        for (int i = 0; i < 4; i++) drive(10'h1FF, 1'b1);
        check_pix("burst", 8'h01, 1'b1, 2'b00, 1'b1);
        rst_n = 1'b0;
        #1;
        check_zero("rst_in_burst");
        @(posedge pclk);
        #1;
        rst_n = 1'b1;
        drive(10'h1FF, 1'b1);
        check("post_rst_unaligned", 32'(bus_if.aligned), 32'd0);
        lock_seq("relock_after_burst_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tmds_decoder.md
TMDS_DECODER -- requirements
Module: tmds_decoder

Interface
REQ-001 SHALL have parameter CTRL_RUN, default 16: consecutive control tokens needed to declare alignment.
REQ-002 SHALL have parameter SEARCH_LIMIT, default 2048: valid words searched at one slip position before slipping.
REQ-003 SHALL have parameter SLIP_WAIT, default 8: clock cycles to wait after a bitslip pulse.
REQ-004 SHALL have parameter LOSS_LIMIT, default 4096: valid words allowed in LOCKED without a qualifying control run.
REQ-005 SHALL have port pclk, input, 1: pixel clock; sole clock domain.
REQ-006 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port tmds_in, input, 10: deserialized TMDS word; bit 0 is the first bit on the wire.
REQ-008 SHALL have port tmds_vld, input, 1: tmds_in is valid this cycle.
REQ-009 SHALL have port bitslip, output, 1: one-cycle request to the deserializer to shift the word boundary by one bit.
REQ-010 SHALL have port aligned, output, 1: word boundary is locked.
REQ-011 SHALL have port dout, output, 8: decoded pixel byte.
REQ-012 SHALL have port de, output, 1: data enable; dout is video data.
REQ-013 SHALL have port c0, output, 1: control bit 0.
REQ-014 SHALL have port c1, output, 1: control bit 1.
REQ-015 SHALL have port dvld, output, 1: dout/de/c0/c1 are valid this cycle.

Function
REQ-016 SHALL decode the control tokens 0x354, 0x0AB, 0x154 and 0x2AB to {c1,c0} = 00, 01, 10 and 11 respectively, with de=0 and dout=0.
REQ-017 SHALL decode every other word with de=1 and c0/c1 holding their last control value, as follows: d = tmds_in[9] ? ~tmds_in[7:0] : tmds_in[7:0]; dout[0] = d[0]; for i=1..7, dout[i] = tmds_in[8] ? d[i]^d[i-1] : ~(d[i]^d[i-1]).
REQ-018 SHALL register the decode in a 2-stage pipeline, so a word sampled with tmds_vld=1 at cycle N appears on dout/de/c0/c1 at cycle N+2.
REQ-019 SHALL assert dvld at N+2 only if tmds_vld=1 and aligned=1 at cycle N; dout/de/c0/c1 SHALL hold their values while dvld=0.
REQ-020 SHALL implement an alignment FSM with states SEARCH, SLIP, WAIT and LOCKED.
REQ-021 SHALL keep a run counter that increments on each valid control token, clears on each valid non-control word, saturates at CTRL_RUN, and holds when tmds_vld=0.
REQ-022 SEARCH: SHALL count valid words; SHALL go to LOCKED when the run counter reaches CTRL_RUN; SHALL go to SLIP when the count reaches SEARCH_LIMIT without a qualifying run.
REQ-023 SHALL give LOCKED priority when the run counter reaches CTRL_RUN on the same cycle that SEARCH_LIMIT expires.
REQ-024 SLIP: SHALL assert bitslip for exactly one cycle, then go to WAIT.
REQ-025 WAIT: SHALL ignore input and clear the run and search counters for SLIP_WAIT cycles, then go to SEARCH.
REQ-026 SHALL hold aligned=1 only in LOCKED.
REQ-027 LOCKED: SHALL clear a loss counter whenever the run counter reaches CTRL_RUN, and otherwise increment it on each valid word.
REQ-028 LOCKED: SHALL go to SEARCH with aligned=0 on the next cycle when the loss counter reaches LOSS_LIMIT, clearing all counters.
REQ-029 SHALL only pulse bitslip from the SLIP state; two bitslip pulses SHALL be separated by at least SLIP_WAIT+1 cycles.
REQ-030 SHALL size all counters to hold their parameter value without wrap-around.

Reset
REQ-031 SHALL, while rst_n=0, force the FSM to SEARCH, all counters to 0, and bitslip, aligned, dout, de, c0, c1 and dvld to 0; this SHALL apply immediately, including mid-slip or mid-decode.
REQ-032 SHALL restart alignment from SEARCH on the first pclk edge after rst_n deasserts.

Verification
REQ-033 Feed 16 consecutive 0x354 words (tmds_vld=1) -> aligned rises after the 16th word; dvld=0 for words before lock.
REQ-034 When LOCKED, feed 0x0AB -> c1c0=01, de=0, dvld=1 two cycles later; feed 0x100 -> de=1, dout=0x00, c1c0 still 01; feed 0x3FF -> dout=0x00 (d=0x00 via the bit-9 invert, bit 8 set), so both words decode to dout=0x00.
REQ-035 Feed 2048 valid 0x1FF words in SEARCH -> single-cycle bitslip pulse; no further bitslip for 8 cycles; SEARCH resumes afterwards.
REQ-036 Feed 15 tokens, one data word, then 15 tokens -> aligned stays 0 (run counter cleared by the data word).
REQ-037 When LOCKED, feed 4096 data words with no control run -> aligned drops to 0 on the next cycle and the FSM is in SEARCH.
REQ-038 Assert rst_n=0 during the bitslip pulse or during a LOCKED data burst -> all outputs 0 immediately; after release, the 16-token lock sequence is required again.
